// File: rtl/jxj_host.sv
// jxj_host: local-bus initiator for the register gateway.
// Each command goes out as a 16-byte packet: a nonce, then a ctl/addr/data word.
// The 16-byte reply is checked against what was sent, and the data word is
// returned to the local bus.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | ready for a command; stray reply bytes are drained as stale
// SEND     | 16 request bytes on out_dout/out_stb, MSB byte first
// END      | one-cycle out_end pulse; timeout counter cleared
// WAIT_RSP | collecting 16 reply bytes or waiting for the timeout
// DONE     | one-cycle rsp_valid with checked result; seq advances
module jxj_host #(
  parameter logic [47:0] NONCE_HI = 48'h4A584A5F5445,
  parameter logic [9:0]  TIMEOUT  = 10'd1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rd,
  input  logic [23:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [2:0]  rsp_err,
  output logic        stale,
  output logic [7:0]  out_dout,
  output logic        out_stb,
  output logic        out_end,
  input  logic [7:0]  in_din,
  input  logic        in_rdy,
  input  logic        in_end,
  output logic        in_stb
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_END,
    S_WAIT_RSP,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [15:0]  seq;
  logic         rd_q;
  logic [63:0]  nonce_q;
  logic [31:0]  hdr_q;
  logic [31:0]  data_q;
  logic [3:0]   tx_cnt;
  logic [3:0]   rx_cnt;
  logic [9:0]   tmo_cnt;
  logic         tmo_q;
  logic [127:0] reply_q;
  logic [31:0]  rsp_data_q;
  logic [2:0]   rsp_err_q;

  logic [127:0] pkt;
  logic [6:0]   tx_bit;
  logic         rx_last;
  logic         tmo_hit;
  logic         nonce_mm;
  logic         hdr_mm;
  logic [31:0]  done_data;
  logic [2:0]   done_err;

  // in_end only signals that the reply source is empty; the byte handshake
  // is carried entirely by in_rdy/in_stb.
  logic unused_in_end;
  assign unused_in_end = in_end;

  // Request packet and the bit offset of the byte currently on the wire
  // (~tx_cnt == 15 - tx_cnt, so byte 0 is pkt[127:120]).
  assign pkt     = {nonce_q, hdr_q, data_q};
  assign tx_bit  = {~tx_cnt, 3'b000};

  // The 16th reply byte is being taken this cycle.
  assign rx_last = in_rdy && (rx_cnt == 4'd15);

  // tmo_cnt is 0 in the first WAIT_RSP cycle; when it reaches TIMEOUT-2
  // the following cycle (DONE) is exactly TIMEOUT cycles after out_end.
  assign tmo_hit = (tmo_cnt == (TIMEOUT - 10'd2));

  // Reply check against the latched request; timeout masks everything.
  assign nonce_mm  = (reply_q[127:64] != nonce_q);
  assign hdr_mm    = (reply_q[63:32] != hdr_q) ||
                     (!rd_q && (reply_q[31:0] != data_q));
  assign done_data = tmo_q ? 32'h0 : reply_q[31:0];
  assign done_err  = tmo_q ? 3'b100 : {1'b0, hdr_mm, nonce_mm};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    out_stb   = 1'b0;
    out_end   = 1'b0;
    out_dout  = 8'h00;
    in_stb    = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = rsp_data_q;
    rsp_err   = rsp_err_q;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        in_stb    = in_rdy;
        if (cmd_valid) state_nxt = S_SEND;
      end
      S_SEND: begin
        out_stb  = 1'b1;
        out_dout = pkt[tx_bit +: 8];
        in_stb   = in_rdy;
        if (tx_cnt == 4'd15) state_nxt = S_END;
      end
      S_END: begin
        out_end   = 1'b1;
        in_stb    = in_rdy;
        state_nxt = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        in_stb = in_rdy;
        if (rx_last || tmo_hit) state_nxt = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        rsp_data  = done_data;
        rsp_err   = done_err;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latch and transmit byte counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= 1'b0;
      nonce_q <= 64'h0;
      hdr_q   <= 32'h0;
      data_q  <= 32'h0;
      tx_cnt  <= 4'd0;
    end else if (state == S_IDLE && cmd_valid) begin
      rd_q    <= cmd_rd;
      nonce_q <= {NONCE_HI, seq};
      hdr_q   <= {3'b000, cmd_rd, 4'b0000, cmd_addr};
      data_q  <= cmd_rd ? 32'h0 : cmd_wdata;
      tx_cnt  <= 4'd0;
    end else if (state == S_SEND) begin
      tx_cnt  <= tx_cnt + 4'd1;
    end
  end

  // Reply shift register, receive counter and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reply_q <= 128'h0;
      rx_cnt  <= 4'd0;
      tmo_cnt <= 10'd0;
      tmo_q   <= 1'b0;
    end else if (state == S_END) begin
      rx_cnt  <= 4'd0;
      tmo_cnt <= 10'd0;
      tmo_q   <= 1'b0;
    end else if (state == S_WAIT_RSP) begin
      tmo_cnt <= tmo_cnt + 10'd1;
      tmo_q   <= tmo_hit && !rx_last;
      if (in_rdy) begin
        reply_q <= {reply_q[119:0], in_din};
        rx_cnt  <= rx_cnt + 4'd1;
      end
    end
  end

  // Result hold registers and sequence number, updated once per DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q <= 32'h0;
      rsp_err_q  <= 3'b000;
      seq        <= 16'h0;
    end else if (state == S_DONE) begin
      rsp_data_q <= done_data;
      rsp_err_q  <= done_err;
      seq        <= seq + 16'h1;
    end
  end

  // Sticky flag: a reply byte was drained while no reply was expected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stale <= 1'b0;
    end else if (in_rdy && (state == S_IDLE || state == S_SEND || state == S_END)) begin
      stale <= 1'b1;
    end
  end

endmodule

// File: doc/jxj_host.md
Name: jxj_host

Overview:
- Initiator for the UDP-style register gateway protocol: turns single local-bus transactions into 16-byte request packets and returns the result.
- Each request packet carries an 8-byte nonce followed by an 8-byte ctl/addr/data word.
- Parses the 16-byte reply: nonce echo, then header echo plus data. Checks the reply against the request and hands read data back.
- Used in simulation benches and in FPGA-side self-test to drive the gateway without a network host.

Parameters:
- NONCE_HI, 48'h4A584A5F5445, fixed upper 48 bits of every nonce.
- TIMEOUT, 1023, cycles allowed from out_end to last reply byte; width 10 bits, range 16..1023.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  transaction request
- cmd_ready  out  1  high in IDLE only
- cmd_rd  in  1  1=read, 0=write
- cmd_addr  in  24  register address
- cmd_wdata  in  32  write data (ignored for reads)
- rsp_valid  out  1  one-cycle pulse, result ready
- rsp_data  out  32  read data, or echoed write data
- rsp_err  out  3  {timeout, header_mismatch, nonce_mismatch}, valid with rsp_valid
- stale  out  1  sticky; set when a byte arrives outside WAIT_RSP
- out_dout  out  8  request byte stream to gateway rx
- out_stb  out  1  byte valid
- out_end  out  1  end-of-packet pulse
- in_din  in  8  reply byte from gateway tx
- in_rdy  in  1  reply byte available
- in_end  in  1  reply source empty (informational only)
- in_stb  out  1  pop reply byte

Behaviour:
- Reset values (async, rst_n low):
  - state=IDLE; all outputs 0 except cmd_ready=1.
  - Sequence counter seq[15:0]=0; stale=0.
- Nonce = {NONCE_HI, seq}.
- Header word = {3'b0, cmd_rd, 4'b0, cmd_addr}, i.e. bit 28 = read flag, bits 23:0 = address.
- Request packet, big-endian, MSB byte first: nonce[63:56] .. nonce[7:0], header[31:24] .. header[7:0], data[31:24] .. data[7:0]. Data is cmd_wdata for writes, 0 for reads.
- State machine:
  - IDLE: cmd_ready=1. On cmd_valid, latch rd/addr/wdata and the nonce, then go to SEND. Accept cycle = T.
  - SEND: out_stb=1 for exactly 16 consecutive cycles T+1..T+16, byte counter 0..15. Go to END.
  - END: out_end=1 for cycle T+17 only; out_stb=0 in that cycle. Clear the timeout counter and go to WAIT_RSP.
  - WAIT_RSP:
    - in_stb = in_rdy. A byte is taken when in_stb=1, shifting into a 128-bit reply register MSB-first. The receive counter counts 0..15.
    - The timeout counter increments every cycle.
    - When the 16th byte is taken, go to DONE.
    - If the counter reaches TIMEOUT first, go to DONE with the timeout bit set.
  - DONE: one cycle.
    - rsp_valid=1.
    - nonce_mismatch = reply[127:64] != sent nonce.
    - header_mismatch = reply[63:32] != sent header.
    - For writes, header_mismatch is also set if reply[31:0] != cmd_wdata.
    - rsp_data = reply[31:0].
    - On timeout, rsp_data=0 and the mismatch bits are 0.
    - seq increments, wrapping 16'hFFFF to 0. Return to IDLE.
- Draining outside WAIT_RSP: in IDLE, SEND and END, in_stb = in_rdy. Bytes are discarded and stale is set (sticky until reset). This flushes late replies after a timeout.
- cmd_valid outside IDLE is ignored (cmd_ready=0). No queuing.
- rsp_data and rsp_err hold their values until the next DONE.
- Reset mid-packet: everything returns to the reset state immediately. A partial packet is abandoned without out_end.

Test Plan:
- Write: cmd_addr=24'h000123, cmd_wdata=32'hDEADBEEF, seq=0, loopback gateway model.
  - out bytes 4A 58 4A 5F 54 45 00 00 00 00 01 23 DE AD BE EF; out_end at T+17.
  - rsp_valid with rsp_err=0, rsp_data=DEADBEEF.
- Read: addr 24'h000010, gateway lb_din=32'h12345678.
  - Header bytes 10 00 00 10.
  - rsp_data=12345678, rsp_err=0, seq now 2.
- No reply, TIMEOUT=16: rsp_valid exactly 16 cycles after the out_end cycle, rsp_err=3'b100, rsp_data=0.
  - Inject 16 late bytes: stale=1, all drained; the next transaction still succeeds.
- Corrupt reply byte 3 (nonce) -> rsp_err=3'b001. Corrupt byte 11 (addr LSB) -> rsp_err=3'b010.
- Reply source throttled: in_rdy low on alternate cycles -> same result as the unthrottled case; in_stb never high while in_rdy low.
- Assert rst_n low at byte 7 of SEND -> outputs 0 immediately, no out_end, cmd_ready=1 after release; seq unchanged=0.
